// File: rtl/cordic_serial_ctrl.sv
// rtl/cordic_serial_ctrl.sv - iteration sequencer for the bit-serial CORDIC datapath
//
// Purpose: steps the CORDIC iteration index through LOAD, then ITERS passes of
// SETUP + RUN, driving the shared i / sel / start / op controls into the x, y
// and z bit-serial slices. It pulses done once after the final pass.
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   go                start a conversion (only looked at in IDLE)
//   zsign             sign of the z residue, latched in SETUP to pick rotation direction
//   xdone/ydone/zdone per-slice pass-complete flags; all three end a RUN pass
//   i [4:0]           iteration index (0 = load operands)
//   sel [3:0]         shifted-operand tap = min(i-1, WIDTH-1), 0 while i=0
//   start             serial pass enable (high only in RUN)
//   op_x/op_y/op_z    adder/subtractor select per slice (1 = subtract)
//   busy              high in every state except IDLE
//   done              one-cycle result-ready pulse
//   err               watchdog fault, sticky until rst or the next accepted go
//
// Configuration: define CORDIC_CTRL_TIMEOUT_EN to add a per-pass watchdog of
// TMO cycles; without it err is tied low and RUN waits indefinitely.

module cordic_serial_ctrl #(
  parameter int WIDTH = 16,
  parameter int ITERS = 15,
  parameter int TMO   = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       go,
  input  logic       zsign,
  input  logic       xdone,
  input  logic       ydone,
  input  logic       zdone,
  output logic [4:0] i,
  output logic [3:0] sel,
  output logic       start,
  output logic       op_x,
  output logic       op_y,
  output logic       op_z,
  output logic       busy,
  output logic       done,
  output logic       err
);

  if (WIDTH < 2 || WIDTH > 16 || ITERS < 1 || ITERS > 31 || TMO < 2) begin : g_bad_params
    $error("cordic_serial_ctrl: parameter out of range");
  end

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SETUP, S_RUN, S_DONE} state_t;

  localparam logic [4:0] LAST_I  = 5'(ITERS);
  localparam logic [4:0] TAP_MAX = 5'(WIDTH - 1);

  state_t     state_q, state_d;
  logic [4:0] i_q, i_d;
  logic [3:0] sel_q, sel_d;
  logic       op_x_q, op_x_d;
  logic       op_y_q, op_y_d;
  logic       op_z_q, op_z_d;
  logic       all_done;
  logic       wd_fire;
  logic [4:0] i_m1;

  assign all_done = xdone & ydone & zdone;
  assign i_m1     = i_q - 5'd1;

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      i_q     <= 5'd0;
      sel_q   <= 4'd0;
      op_x_q  <= 1'b0;
      op_y_q  <= 1'b0;
      op_z_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      sel_q   <= sel_d;
      op_x_q  <= op_x_d;
      op_y_q  <= op_y_d;
      op_z_q  <= op_z_d;
    end
  end

  // Next state; i, sel and op_* only move on state transitions, so they
  // stay frozen for the whole of RUN.
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    sel_d   = sel_q;
    op_x_d  = op_x_q;
    op_y_d  = op_y_q;
    op_z_d  = op_z_q;
    unique case (state_q)
      S_IDLE: begin
        if (go) state_d = S_LOAD;
      end
      S_LOAD: begin
        i_d     = 5'd1;
        state_d = S_SETUP;
      end
      S_SETUP: begin
        // Rotate toward z=0: a negative residue flips all three operations.
        op_y_d  = zsign;
        op_x_d  = ~zsign;
        op_z_d  = ~zsign;
        sel_d   = (i_m1 > TAP_MAX) ? TAP_MAX[3:0] : i_m1[3:0];
        state_d = S_RUN;
      end
      S_RUN: begin
        if (wd_fire) begin
          i_d     = 5'd0;
          sel_d   = 4'd0;
          state_d = S_IDLE;
        end else if (all_done) begin
          if (i_q == LAST_I) begin
            state_d = S_DONE;
          end else begin
            i_d     = i_q + 5'd1;
            state_d = S_SETUP;
          end
        end
      end
      S_DONE: begin
        i_d     = 5'd0;
        sel_d   = 4'd0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from state so an asynchronous reset clears them at once
  always_comb begin
    start = (state_q == S_RUN);
    busy  = (state_q != S_IDLE);
    done  = (state_q == S_DONE);
  end

  assign i    = i_q;
  assign sel  = sel_q;
  assign op_x = op_x_q;
  assign op_y = op_y_q;
  assign op_z = op_z_q;

`ifdef CORDIC_CTRL_TIMEOUT_EN
  localparam int WD_W = $clog2(TMO + 1);

  logic [WD_W-1:0] wd_q, wd_d;
  logic            err_q, err_d;

  // Fires on the TMO-th RUN cycle unless the pass completes in that same cycle.
  assign wd_fire = (state_q == S_RUN) && !all_done && (wd_q == WD_W'(TMO - 1));

  always_comb begin
    wd_d  = wd_q;
    err_d = err_q;
    if (state_q == S_SETUP)    wd_d = '0;
    else if (state_q == S_RUN) wd_d = wd_q + 1'b1;
    if (state_q == S_IDLE && go) err_d = 1'b0;
    if (wd_fire) err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign wd_fire = 1'b0;
  assign err     = 1'b0;
`endif

endmodule

// File: tb/tb_cordic_serial_ctrl.sv
// tb/tb_cordic_serial_ctrl.sv - self-checking bench for cordic_serial_ctrl
module tb_cordic_serial_ctrl;

  localparam int W   = 16;
  localparam int N   = 15;
  localparam int N20 = 20;
`ifdef CORDIC_CTRL_TIMEOUT_EN
  localparam int EMAX = 1;
`else
  localparam int EMAX = 3;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, go, zsign, xdone, ydone, zdone;
  logic [4:0] i;
  logic [3:0] sel;
  logic       start, op_x, op_y, op_z, busy, done, err;

  logic       rst20, go20, zsign20, dn20;
  logic [4:0] i20;
  logic [3:0] sel20;
  logic       start20, ox20, oy20, oz20, busy20, done20, err20;

  cordic_serial_ctrl #(.WIDTH(W), .ITERS(N), .TMO(20)) dut (
    .clk(clk), .rst(rst), .go(go), .zsign(zsign),
    .xdone(xdone), .ydone(ydone), .zdone(zdone),
    .i(i), .sel(sel), .start(start), .op_x(op_x), .op_y(op_y), .op_z(op_z),
    .busy(busy), .done(done), .err(err)
  );

  cordic_serial_ctrl #(.WIDTH(W), .ITERS(N20), .TMO(20)) dut20 (
    .clk(clk), .rst(rst20), .go(go20), .zsign(zsign20),
    .xdone(dn20), .ydone(dn20), .zdone(dn20),
    .i(i20), .sel(sel20), .start(start20), .op_x(ox20), .op_y(oy20), .op_z(oz20),
    .busy(busy20), .done(done20), .err(err20)
  );

  // Behavioural slices: count shifts while start is high, raise done one
  // cycle after WIDTH (+extra) shifts, clear whenever start is low.
  int extra[3] = '{0, 0, 0};
  bit stuck[3] = '{0, 0, 0};
  int scnt[3]  = '{0, 0, 0};
  bit sfl[3]   = '{0, 0, 0};
  int c20      = 0;
  bit f20      = 1'b0;

  always @(posedge clk) begin
    for (int s = 0; s < 3; s++) begin
      if (!start) begin
        scnt[s] <= 0;
        sfl[s]  <= 1'b0;
      end else begin
        scnt[s] <= scnt[s] + 1;
        if (scnt[s] >= W + extra[s]) sfl[s] <= 1'b1;
      end
    end
    if (!start20) begin
      c20 <= 0;
      f20 <= 1'b0;
    end else begin
      c20 <= c20 + 1;
      if (c20 >= W) f20 <= 1'b1;
    end
  end

  assign xdone = sfl[0] & ~stuck[0];
  assign ydone = sfl[1] & ~stuck[1];
  assign zdone = sfl[2] & ~stuck[2];
  assign dn20  = f20;

  logic [15:0] obs;
  assign obs = {i, sel, start, op_x, op_y, op_z, busy, done, err};

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int minv(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [15:0] vec(input int ii, input int ss, input bit st,
                                      input logic [2:0] ops, input bit bs, input bit dn,
                                      input bit er);
    return {ii[4:0], ss[3:0], st, ops, bs, dn, er};
  endfunction

  // Reference state carried across conversions: last latched sel and ops.
  int         cur_sel = 0;
  logic [2:0] cur_ops = 3'b000;

  // One conversion, checked every cycle against the pass timing model:
  // cycle 1 LOAD, pass k occupies P cycles starting with SETUP, then DONE.
  task automatic run_conv(input bit hold_go, input int ex, input int ey, input int ez,
                          input int zmode, output int first_done);
    int P, D, k, o, mx;
    bit zs[32];
    logic [15:0] e;
    extra[0] = ex; extra[1] = ey; extra[2] = ez;
    mx = (ex > ey) ? ((ex > ez) ? ex : ez) : ((ey > ez) ? ey : ez);
    P = W + 3 + mx;
    D = 2 + N * P;
    for (int kk = 1; kk <= N; kk++) zs[kk] = (zmode == 2) ? 1'($urandom) : zmode[0];
    first_done = -1;
    go = 1'b1;
    for (int c = 1; c <= D + 1; c++) begin
      @(negedge clk);
      if (c == 1) begin
        e = vec(0, 0, 0, cur_ops, 1, 0, 0);
      end else if (c < D) begin
        k = (c - 2) / P + 1;
        o = (c - 2) % P;
        if (o == 1) begin
          cur_sel = minv(k - 1, W - 1);
          cur_ops = {~zs[k], zs[k], ~zs[k]};
        end
        e = vec(k, cur_sel, o != 0, cur_ops, 1, 0, 0);
      end else if (c == D) begin
        e = vec(N, cur_sel, 0, cur_ops, 1, 1, 0);
      end else begin
        cur_sel = 0;
        e = vec(0, 0, 0, cur_ops, 0, 0, 0);
      end
      check("cyc", obs, e);
      if (done && first_done < 0) first_done = c;
      go    = (c < D && !hold_go) ? 1'($urandom) : hold_go;
      zsign = (c >= 2 && c < D && (c - 2) % P == 0) ? zs[(c - 2) / P + 1] : 1'($urandom);
    end
    check("latency", first_done, D);
  endtask

  initial begin
    int fd, found, seen, k20, fd20;
    bit prev20;
    rst = 1'b1; go = 1'b0; zsign = 1'b0;
    rst20 = 1'b1; go20 = 1'b0; zsign20 = 1'b0;
    repeat (3) @(negedge clk);
    check("reset", obs, 0);
    rst = 1'b0; rst20 = 1'b0;
    @(negedge clk);
    fork
      begin
        run_conv(0, 0, 0, 0, 0, fd);
        check("lat287", fd, 287);
        run_conv(0, 0, 0, 0, 1, fd);
`ifndef CORDIC_CTRL_TIMEOUT_EN
        run_conv(0, 0, 0, 3, 2, fd);
        check("lat_zdelay", fd, 2 + N * (W + 6));
`endif
        for (int t = 0; t < 5; t++) begin
          run_conv((t < 4) ? 1'($urandom) : 1'b0, $urandom_range(0, EMAX),
                   $urandom_range(0, EMAX), $urandom_range(0, EMAX), 2, fd);
        end
        go = 1'b0;
        @(negedge clk);

        // Asynchronous reset in the middle of the i=7 pass
        extra[0] = 0; extra[1] = 0; extra[2] = 0;
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        found = 0;
        for (int c = 0; c < 400 && found == 0; c++) begin
          @(negedge clk);
          if (start && i == 5'd7) found = 1;
        end
        check("rst_find", found, 1);
        rst = 1'b1;
        #1;
        check("rst_async", obs, 0);
        @(negedge clk);
        rst = 1'b0;
        cur_ops = 3'b000;
        cur_sel = 0;
        seen = 0;
        repeat (40) begin
          @(negedge clk);
          if (done || busy) seen = 1;
        end
        check("rst_quiet", seen, 0);
        run_conv(0, 0, 0, 0, 2, fd);

`ifdef CORDIC_CTRL_TIMEOUT_EN
        // zdone stuck low: watchdog after 20 RUN cycles
        go = 1'b0;
        @(negedge clk);
        stuck[2] = 1'b1;
        zsign = 1'b0;
        go = 1'b1;
        seen = 0;
        for (int c = 1; c <= 23; c++) begin
          @(negedge clk);
          go = 1'b0;
          if (done) seen = 1;
          if (c == 22) check("tmo_run", {start, err, busy}, 3'b101);
          if (c == 23) check("tmo_err", {start, err, busy, done}, 4'b0100);
        end
        check("tmo_nodone", seen, 0);
        stuck[2] = 1'b0;
        cur_ops = 3'b101;
        cur_sel = 0;
        repeat (3) @(negedge clk);
        check("err_sticky", err, 1);
        run_conv(0, 0, 0, 0, 2, fd);
`endif
        go = 1'b0;
      end
      begin
        // ITERS=20 instance: sel must clamp at WIDTH-1 from i=17 on
        go20 = 1'b1;
        k20 = 0;
        prev20 = 1'b0;
        fd20 = -1;
        for (int c = 1; c <= 450; c++) begin
          @(negedge clk);
          go20 = 1'b0;
          if (start20 && !prev20) begin
            k20++;
            check("sel20", {i20, sel20}, {k20[4:0], 4'(minv(k20 - 1, W - 1))});
          end
          prev20 = start20;
          if (done20 && fd20 < 0) fd20 = c;
        end
        check("passes20", k20, N20);
        check("lat20", fd20, 2 + N20 * (W + 3));
      end
    join
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
